exp_pipe_arbiter: RTL and testbench
===================================

// Module: exp_pipe_arbiter
// PURPOSE
//  Shares one exp_pipelined datapath between NREQ requesters. Round-robin arbiter issues at most one
//  argument per clock into the pipeline and tags it with the requester index in a shadow valid/tag
//  shift register matching pipeline latency. Results are collected in a result FIFO with
//  valid/ready output. Credit logic guarantees no result is ever dropped, because the exp pipeline
//  itself has no stall.
// PARAMETERS
//  NREQ        4   number of requesters (>=2)
//  ARG_W       20  argument width, = ARG_HIGH+ARG_LOW of the attached exp_pipelined
//  RES_W       32  result width, = RES_HIGH+RES_LOW of the attached exp_pipelined
//  LATENCY     33  clocks from pipe_x update to matching pipe_res, = STEPS+1 of exp_pipelined
//  FIFO_DEPTH  36  result FIFO entries (>=1; >=LATENCY+2 for one result per clock sustained)
//  TAG_W       $clog2(NREQ)  derived, not overridden
// PORTS
//  clk        in   1            clock, all state on posedge
//  rst_n      in   1            asynchronous active-low reset
//  req_valid  in   NREQ         per-requester argument valid
//  req_arg    in   NREQ*ARG_W   packed arguments, requester i at [i*ARG_W +: ARG_W], signed
//  req_ready  out  NREQ         one-hot grant; handshake when req_valid[i]&req_ready[i]
//  pipe_x     out  ARG_W        registered argument to exp_pipelined.ix
//  pipe_res   in   RES_W        exp_pipelined.oexp
//  res_valid  out  1            FIFO head valid
//  res_ready  in   1            consumer accepts head
//  res_data   out  RES_W        FIFO head result
//  res_tag    out  TAG_W        requester index that issued res_data
//  busy       out  1            any issue in flight or FIFO not empty
// BEHAVIOUR
//  Reset (async, rst_n=0): req_ready=0, pipe_x=0, res_valid=0, res_data=0, res_tag=0, busy=0.
//   RR pointer=0, all shadow valids=0, FIFO empty, credit count=0. Released synchronously.
//  Credit: cnt = in-flight count + FIFO occupancy, both registered.
//   Issue allowed only when cnt < FIFO_DEPTH.
//   No combinational path from res_ready or pipe_res to req_ready.
//  Arbitration: when allowed, grant the first i with req_valid[i], searching ptr, ptr+1, ... mod NREQ.
//   req_ready is combinational from req_valid, ptr and cnt, and is at most one-hot.
//   After a handshake on i, ptr <= (i+1) mod NREQ; otherwise ptr holds.
//   Requesters hold req_valid/req_arg stable until their handshake; there is no withdraw.
//  Issue (handshake edge E): pipe_x <= req_arg[i]; shadow stage 0 <= {1, i}. No handshake: pipe_x
//   holds its value and stage 0 valid <= 0.
//   Shadow stages shift every clock, with stages 0..LATENCY-1.
//  Capture: in the cycle where stage LATENCY-1 is valid, pipe_res is that argument's result.
//   At the next edge {pipe_res, tag} is written to the FIFO.
//   The earliest res_valid is the cycle after edge E+LATENCY+1, which is LATENCY+1 clocks after
//   the handshake.
//  FIFO: first-word-fall-through, registered head. Pop on res_valid&res_ready.
//   Simultaneous push and pop keeps occupancy. Push into a full FIFO is impossible by credit; the
//   bench asserts this.
//   Pointers wrap modulo FIFO_DEPTH. res_data/res_tag hold while res_valid&!res_ready.
//  cnt update per edge: +1 on issue, -1 on pop, both means unchanged.
//   Capture moves an entry from in-flight to FIFO, so cnt is unchanged.
//  Ordering: results leave in issue order across all requesters.
//  Reset mid-operation clears all shadow valids and the FIFO. Results still inside exp_pipelined
//   are discarded, because their shadow valid is 0. The pipeline is not reset.
//  Width: data passes through unmodified; no arithmetic on arg/result.
// TESTING
//  1. Single request: req 2 arg 20'h0 -> one-cycle handshake; res_valid exactly LATENCY+1 clocks
//     later; res_data=32'h0001_0000; res_tag=2.
//  2. All 4 requesters valid continuously, res_ready=1 -> grants 0,1,2,3,0,... one per clock;
//     results stream back-to-back in the same tag order.
//  3. res_ready=0, continuous requests -> exactly FIFO_DEPTH handshakes, then req_ready=0.
//     With res_ready=1, one pop frees one issue. No loss, no FIFO-full push assertion.
//  4. FIFO_DEPTH=1 build, back-to-back requests -> at most one issue per LATENCY+2 clocks; data
//     and tags correct.
//  5. rst_n low for 1 clock with 10 in flight -> all outputs 0 immediately; no stale res_valid
//     after release; the next request returns normally.
//  6. req 1 and req 3 valid with ptr=2 -> req 3 granted first, then req 1; ptr wraps 3->0.

Source files
------------

// File: rtl/exp_pipe_arbiter_if.sv
// Requester and result-stream signals of exp_pipe_arbiter.
// master = requester/consumer side, slave = arbiter side.
interface exp_pipe_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int ARG_W = 20,
  parameter int RES_W = 32,
  parameter int TAG_W = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*ARG_W-1:0] req_arg;
  logic [NREQ-1:0]       req_ready;
  logic                  res_valid;
  logic                  res_ready;
  logic [RES_W-1:0]      res_data;
  logic [TAG_W-1:0]      res_tag;

  modport master (
    output req_valid, req_arg, res_ready,
    input  req_ready, res_valid, res_data, res_tag
  );

  modport slave (
    input  req_valid, req_arg, res_ready,
    output req_ready, res_valid, res_data, res_tag
  );
endinterface

// File: rtl/exp_pipe_arbiter.sv
// Round-robin front end sharing one stall-free exp pipeline between NREQ requesters,
// with a tag shadow line, a credit counter and a first-word-fall-through result FIFO.
module exp_pipe_arbiter #(
  parameter  int NREQ       = 4,
  parameter  int ARG_W      = 20,
  parameter  int RES_W      = 32,
  parameter  int LATENCY    = 33,
  parameter  int FIFO_DEPTH = 36,
  localparam int TAG_W      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  exp_pipe_arbiter_if.slave bus,
  output logic [ARG_W-1:0]  pipe_x,
  input  logic [RES_W-1:0]  pipe_res,
  output logic              busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(FIFO_DEPTH - 1);

  logic             issue_en;
  logic [TAG_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  logic [LATENCY-1:0] sh_valid;
  logic [TAG_W-1:0]   sh_tag [LATENCY];

  logic [RES_W-1:0] mem_data [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_tag  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] mem_cnt;

  logic             issue;
  logic [TAG_W-1:0] grant_idx;
  logic [TAG_W-1:0] next_ptr;
  logic             capture;
  logic             pop;
  logic             head_load;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  // Grant depends only on req_valid and registered state, never on res_ready or pipe_res.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    issue         = 1'b0;
    grant_idx     = '0;
    bus.req_ready = '0;
    if (issue_en && (cnt < DEPTH_C)) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!issue && bus.req_valid[(int'(ptr) + k) % NREQ]) begin
          issue     = 1'b1;
          grant_idx = TAG_W'((int'(ptr) + k) % NREQ);
        end
      end
    end
    if (issue) bus.req_ready[grant_idx] = 1'b1;
  end

  assign next_ptr  = TAG_W'((int'(grant_idx) + 1) % NREQ);
  assign capture   = sh_valid[LATENCY-1];
  assign pop       = bus.res_valid && bus.res_ready;
  assign head_load = (mem_cnt != '0) && (!bus.res_valid || pop);
  assign busy      = (cnt != '0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_en      <= 1'b0;
      ptr           <= '0;
      cnt           <= '0;
      pipe_x        <= '0;
      sh_valid      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      mem_cnt       <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_tag   <= '0;
    end else begin
      issue_en <= 1'b1;

      if (issue) begin
        ptr    <= next_ptr;
        pipe_x <= bus.req_arg[int'(grant_idx)*ARG_W +: ARG_W];
      end
      sh_valid <= {sh_valid[LATENCY-2:0], issue};

      // Capture only moves an entry from in-flight to FIFO, so it leaves cnt alone.
      case ({issue, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase

      if (capture)   wr_ptr <= wrap_inc(wr_ptr);
      if (head_load) rd_ptr <= wrap_inc(rd_ptr);
      case ({capture, head_load})
        2'b10:   mem_cnt <= mem_cnt + 1'b1;
        2'b01:   mem_cnt <= mem_cnt - 1'b1;
        default: mem_cnt <= mem_cnt;
      endcase

      if (head_load) begin
        bus.res_valid <= 1'b1;
        bus.res_data  <= mem_data[rd_ptr];
        bus.res_tag   <= mem_tag[rd_ptr];
      end else if (pop) begin
        bus.res_valid <= 1'b0;
      end
    end
  end

  // NOTE: tag line and FIFO storage carry no reset; the valid bits and counters qualify them.
  always_ff @(posedge clk) begin
    sh_tag[0] <= grant_idx;
    for (int k = 1; k < LATENCY; k++) sh_tag[k] <= sh_tag[k-1];
    if (capture) begin
      mem_data[wr_ptr] <= pipe_res;
      mem_tag[wr_ptr]  <= sh_tag[LATENCY-1];
    end
  end

endmodule

// File: tb/tb_exp_pipe_arbiter.sv
// Directed bench for exp_pipe_arbiter: a delay-line stand-in for the exp pipeline,
// a requester engine with a scoreboard, and a FIFO_DEPTH=1 instance for credit throttling.
module tb_exp_pipe_arbiter;
  localparam int N  = 4;
  localparam int AW = 20;
  localparam int RW = 32;
  localparam int TW = 2;
  localparam int L  = 33;
  localparam int D  = 36;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exp_pipe_arbiter_if #(.NREQ(N), .ARG_W(AW), .RES_W(RW)) bus ();
  exp_pipe_arbiter_if #(.NREQ(N), .ARG_W(AW), .RES_W(RW)) bus1 ();
  logic [AW-1:0] pipe_x, pipe_x1;
  logic [RW-1:0] pipe_res, pipe_res1;
  logic          busy, busy1;

  exp_pipe_arbiter #(.NREQ(N), .ARG_W(AW), .RES_W(RW), .LATENCY(L), .FIFO_DEPTH(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .pipe_x(pipe_x), .pipe_res(pipe_res), .busy(busy));

  exp_pipe_arbiter #(.NREQ(N), .ARG_W(AW), .RES_W(RW), .LATENCY(L), .FIFO_DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .pipe_x(pipe_x1), .pipe_res(pipe_res1), .busy(busy1));

  // Stand-in datapath: any injective map works since the arbiter never touches the data.
  function automatic logic [RW-1:0] fexp(input logic [AW-1:0] x);
    return 32'h0001_0000 ^ {12'h000, x};
  endfunction

  logic [AW-1:0] pdly  [L-1];
  logic [AW-1:0] pdly1 [L-1];
  always @(posedge clk) begin
    pdly[0]  <= pipe_x;
    pdly1[0] <= pipe_x1;
    for (int k = 1; k < L-1; k++) begin
      pdly[k]  <= pdly[k-1];
      pdly1[k] <= pdly1[k-1];
    end
  end
  assign pipe_res  = fexp(pdly[L-2]);
  assign pipe_res1 = fexp(pdly1[L-2]);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ovf = 0;
  always @(negedge clk) begin
    if ((u_dut.capture && u_dut.mem_cnt == D) || (u_dut1.capture && u_dut1.mem_cnt == 1))
      ovf <= ovf + 1;
  end

  // Requester engine for u_dut: drives at negedge, samples 4 time units later.
  int               left   [N];
  logic [AW-1:0]    arg_of [N];
  logic [TW+RW-1:0] sb [$];
  int               hs_log [$];
  int               hs_cyc [$];
  int               pop_log[$];
  int               pop_cyc[$];
  int               hs_count = 0;
  int               pops = 0;
  int               rv_samples = 0;
  int               rv_first = -1;
  int               onehot_err = 0;
  logic [RW-1:0]    last_data;
  logic [N-1:0]     hs_main;

  initial begin
    int  hs_i;
    bit  hs_pend;
    logic [TW+RW-1:0] want;
    hs_pend = 1'b0;
    hs_i    = 0;
    forever begin
      @(negedge clk);
      if (hs_pend) begin
        left[hs_i]--;
        arg_of[hs_i] = arg_of[hs_i] + 20'h00011;
        hs_pend = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        bus.req_valid[i]          = (left[i] > 0);
        bus.req_arg[i*AW +: AW]   = arg_of[i];
      end
      #4;
      hs_main = bus.req_valid & bus.req_ready;
      if (!$onehot0(bus.req_ready)) onehot_err++;
      for (int i = 0; i < N; i++) begin
        if (hs_main[i]) begin
          hs_i    = i;
          hs_pend = 1'b1;
          hs_count++;
          hs_log.push_back(i);
          hs_cyc.push_back(cyc);
          sb.push_back({TW'(i), fexp(arg_of[i])});
        end
      end
      if (bus.res_valid) begin
        rv_samples++;
        if (rv_first < 0) rv_first = cyc;
      end
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          want = sb.pop_front();
          check("res_data", bus.res_data, want[RW-1:0]);
          check("res_tag", bus.res_tag, want[TW+RW-1:RW]);
        end
        pops++;
        pop_log.push_back(int'(bus.res_tag));
        pop_cyc.push_back(cyc);
        last_data = bus.res_data;
      end
    end
  end

  function automatic bit any_left();
    for (int i = 0; i < N; i++) if (left[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while ((any_left() || sb.size() != 0 || busy) && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, n < max, 1);
  endtask

  task automatic wait_hs_log(input int sz, input int max);
    int n = 0;
    while (hs_log.size() < sz && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check("hs_wait", n < max, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, pbase;
    logic [N-1:0]     b_done;
    logic [AW-1:0]    b_arg [N];
    logic [TW+RW-1:0] sb1 [$];
    logic [TW+RW-1:0] want1;
    logic [N-1:0]     hs1;
    int               b_tags[$];
    int               b_hs_cyc[$];
    int               b_pops;
    int               b_pend;

    for (int i = 0; i < N; i++) begin
      left[i]   = 0;
      arg_of[i] = '0;
    end
    rst_n           = 1'b0;
    bus.res_ready   = 1'b0;
    bus1.req_valid  = '0;
    bus1.req_arg    = '0;
    bus1.res_ready  = 1'b0;

    // Reset state with all requesters asserting valid
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < N; i++) left[i] = 1;
    repeat (2) @(posedge clk); #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_pipe_x", pipe_x, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_tag", bus.res_tag, 0);
    check("rst_busy", busy, 0);
    for (int i = 0; i < N; i++) left[i] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;

    // 1: single request from requester 2 with argument 0
    bus.res_ready = 1'b1;
    rv_first = -1;
    hs_log.delete(); hs_cyc.delete(); pop_log.delete();
    left[2] = 1;
    arg_of[2] = '0;
    @(posedge clk); #1;
    check("t1_one_cycle_hs", hs_log.size(), 1);
    wait_idle("t1_done", 100);
    if (hs_cyc.size() > 0) check("t1_latency", rv_first - hs_cyc[0] - 1, L + 1);
    check("t1_tag", pop_log.size() > 0 ? pop_log[0] : -1, 2);
    check("t1_data", last_data, 32'h0001_0000);

    // 2: all requesters continuously valid; ptr first moved to 0 by one grant to requester 3
    left[3] = 1;
    wait_idle("t2_pre", 100);
    hs_log.delete(); hs_cyc.delete(); pop_log.delete(); pop_cyc.delete();
    for (int i = 0; i < N; i++) left[i] = 8;
    wait_idle("t2_done", 300);
    check("t2_hs_count", hs_log.size(), 32);
    for (int k = 0; k < hs_log.size() && k < 32; k++) check("t2_grant_order", hs_log[k], k % 4);
    for (int k = 0; k < pop_log.size() && k < 32; k++) check("t2_result_order", pop_log[k], k % 4);
    if (hs_cyc.size() == 32)  check("t2_issue_span", hs_cyc[31] - hs_cyc[0], 31);
    if (pop_cyc.size() == 32) check("t2_result_span", pop_cyc[31] - pop_cyc[0], 31);

    // 3: consumer stalled, credit limits issues to FIFO_DEPTH
    bus.res_ready = 1'b0;
    base  = hs_count;
    pbase = pops;
    for (int i = 0; i < N; i++) left[i] = 20;
    repeat (120) @(posedge clk); #1;
    check("t3_credit_issues", hs_count - base, D);
    check("t3_ready_blocked", bus.req_ready, 0);
    check("t3_no_pop", pops - pbase, 0);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("t3_one_pop", pops - pbase, 1);
    check("t3_one_issue", hs_count - base, D + 1);
    bus.res_ready = 1'b1;
    wait_idle("t3_drain", 600);
    check("t3_all_returned", pops - pbase, 80);

    // 5: reset with 10 results in flight
    base = hs_count;
    left[0] = 10;
    for (int n = 0; n < 40 && hs_count - base < 10; n++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk); #1;
    check("t5_ten_in_flight", hs_count - base, 10);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("t5_rst_req_ready", bus.req_ready, 0);
    check("t5_rst_pipe_x", pipe_x, 0);
    check("t5_rst_res_valid", bus.res_valid, 0);
    check("t5_rst_res_data", bus.res_data, 0);
    check("t5_rst_res_tag", bus.res_tag, 0);
    check("t5_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rv_samples = 0;
    repeat (L + 10) @(posedge clk); #1;
    check("t5_no_stale", rv_samples, 0);
    pop_log.delete();
    left[1] = 1;
    arg_of[1] = 20'h12345;
    wait_idle("t5_after", 100);
    check("t5_tag", pop_log.size() > 0 ? pop_log[0] : -1, 1);
    check("t5_data", last_data, 32'h0000_2345);

    // 6: ptr at 2 with requesters 1 and 3 valid
    left[1] = 1;
    wait_idle("t6_pre", 100);
    check("t6_ptr_start", u_dut.ptr, 2);
    hs_log.delete();
    left[1] = 1;
    left[3] = 1;
    wait_hs_log(1, 20);
    check("t6_first_grant", hs_log.size() > 0 ? hs_log[0] : -1, 3);
    check("t6_ptr_wrap", u_dut.ptr, 0);
    wait_hs_log(2, 20);
    check("t6_second_grant", hs_log.size() > 1 ? hs_log[1] : -1, 1);
    check("t6_ptr_after", u_dut.ptr, 2);
    wait_idle("t6_done", 100);

    // 4: FIFO_DEPTH=1 instance, every requester valid at once
    b_done = '0;
    b_pops = 0;
    b_pend = -1;
    for (int i = 0; i < N; i++) b_arg[i] = AW'(i * 257 + 5);
    for (int n = 0; n < 400 && b_pops < N; n++) begin
      @(posedge clk); #1;
      if (b_pend >= 0) begin
        b_done[b_pend] = 1'b1;
        b_pend = -1;
      end
      for (int i = 0; i < N; i++) begin
        bus1.req_valid[i]        = !b_done[i];
        bus1.req_arg[i*AW +: AW] = b_arg[i];
      end
      bus1.res_ready = 1'b1;
      @(negedge clk);
      hs1 = bus1.req_valid & bus1.req_ready;
      for (int i = 0; i < N; i++) begin
        if (hs1[i]) begin
          b_pend = i;
          b_tags.push_back(i);
          b_hs_cyc.push_back(cyc);
          sb1.push_back({TW'(i), fexp(b_arg[i])});
        end
      end
      if (bus1.res_valid) begin
        if (sb1.size() == 0) begin
          check("t4_unexpected_result", 1, 0);
        end else begin
          want1 = sb1.pop_front();
          check("t4_data", bus1.res_data, want1[RW-1:0]);
          check("t4_tag", bus1.res_tag, want1[TW+RW-1:RW]);
        end
        b_pops++;
      end
    end
    check("t4_pops", b_pops, N);
    for (int k = 0; k < b_tags.size(); k++) check("t4_grant_order", b_tags[k], k);
    for (int k = 1; k < b_hs_cyc.size(); k++)
      check("t4_issue_gap", (b_hs_cyc[k] - b_hs_cyc[k-1]) >= L + 2, 1);

    check("no_full_push", ovf, 0);
    check("grant_onehot", onehot_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
